memory_stage: RTL and testbench

Memory stage of the rv32i five-stage pipeline. Consumes the M-stage control and data registers produced by the execute stage. Performs word loads and stores over a request/grant/response data-memory port, stalling upstream while an access is outstanding. Registers the W-stage control, ALU result, load data and destination register for the writeback stage.

---
 rtl/rv32i_pkg.sv | 11 +
 rtl/mem_watchdog.sv | 26 ++
 rtl/memory_stage.sv | 131 +++++++++++++
 tb/tb_memory_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared rv32i datapath width and memory-stage FSM state type
package rv32i_pkg;

  localparam int DPW = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - consecutive stalled-cycle counter; expires at LIMIT-1 (used under MEM_TIMEOUT_EN)
module mem_watchdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [7:0] count;

  assign expire = en && (count == 8'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clr || expire) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - rv32i M stage: dmem req/gnt/rvalid handshake, stall, W registers; MEM_TIMEOUT_EN adds abort
module memory_stage
  import rv32i_pkg::*;
#(
  parameter int DPW            = rv32i_pkg::DPW,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           regwriteM,
  input  logic           resultsrcM,
  input  logic           memwriteM,
  input  logic [DPW-1:0] aluresultM,
  input  logic [DPW-1:0] Rd2M,
  input  logic [4:0]     RdM,
  output logic           stall_o,
  output logic           dmem_req_o,
  output logic           dmem_we_o,
  output logic [DPW-1:0] dmem_addr_o,
  output logic [DPW-1:0] dmem_wdata_o,
  input  logic           dmem_gnt_i,
  input  logic           dmem_rvalid_i,
  input  logic [DPW-1:0] dmem_rdata_i,
  output logic           regwriteW,
  output logic           resultsrcW,
  output logic [DPW-1:0] aluresultW,
  output logic [DPW-1:0] readdataW,
  output logic [4:0]     RdW,
  output logic           mem_err_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("memory_stage: TIMEOUT_CYCLES must be in 2..255");
  end

  mem_state_t state, state_next;
  logic access, req, complete, stall_raw, abort, load_done;

  assign access       = memwriteM || resultsrcM;
  assign dmem_we_o    = memwriteM;
  assign dmem_addr_o  = aluresultM;
  assign dmem_wdata_o = Rd2M;

  always_comb begin
    state_next = state;
    req        = 1'b0;
    complete   = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          req = 1'b1;
          if (memwriteM) begin
            complete = dmem_gnt_i;
          end else if (dmem_gnt_i) begin
            if (dmem_rvalid_i) complete = 1'b1;
            else               state_next = RESP;
          end
        end
      end
      RESP: begin
        if (dmem_rvalid_i) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  assign stall_raw  = ((state == RESP) || access) && !complete;
  assign load_done  = complete && ((state == RESP) || !memwriteM);
  // Reset gates the combinational outputs so nothing is requested while held in reset.
  assign stall_o    = stall_raw && !abort && !rst;
  assign dmem_req_o = req && !rst;

`ifdef MEM_TIMEOUT_EN
  mem_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (!stall_raw),
    .en     (stall_raw),
    .expire (abort)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_err_o <= 1'b0;
    else     mem_err_o <= abort;
  end
`else
  assign abort     = 1'b0;
  assign mem_err_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stalled cycles write a bubble; the completing cycle writes the instruction once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwriteW  <= 1'b0;
      resultsrcW <= 1'b0;
      aluresultW <= '0;
      readdataW  <= '0;
      RdW        <= 5'd0;
    end else if (stall_o) begin
      regwriteW  <= 1'b0;
      resultsrcW <= 1'b0;
      aluresultW <= aluresultM;
      RdW        <= 5'd0;
    end else if (abort) begin
      regwriteW  <= 1'b0;
      resultsrcW <= resultsrcM;
      aluresultW <= aluresultM;
      readdataW  <= '0;
      RdW        <= RdM;
    end else begin
      regwriteW  <= regwriteM;
      resultsrcW <= resultsrcM;
      aluresultW <= aluresultM;
      RdW        <= RdM;
      if (load_done) readdataW <= dmem_rdata_i;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage (abort case only with MEM_TIMEOUT_EN)
module tb_memory_stage;
  import rv32i_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            regwriteM, resultsrcM, memwriteM;
  logic [31:0]     aluresultM, Rd2M, dmem_rdata_i;
  logic [4:0]      RdM, RdW;
  logic            stall_o, dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [31:0]     dmem_addr_o, dmem_wdata_o, aluresultW, readdataW;
  logic            regwriteW, resultsrcW, mem_err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_stage #(.DPW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .regwriteM     (regwriteM),
    .resultsrcM    (resultsrcM),
    .memwriteM     (memwriteM),
    .aluresultM    (aluresultM),
    .Rd2M          (Rd2M),
    .RdM           (RdM),
    .stall_o       (stall_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .regwriteW     (regwriteW),
    .resultsrcW    (resultsrcW),
    .aluresultW    (aluresultW),
    .readdataW     (readdataW),
    .RdW           (RdW),
    .mem_err_o     (mem_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    regwriteM = 0; resultsrcM = 0; memwriteM = 0;
    aluresultM = 0; Rd2M = 0; RdM = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    resultsrcM = 1; dmem_gnt_i = 1;
    tick(); tick();
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_regwriteW", {31'd0, regwriteW}, 32'd0);
    chk("rst_aluresultW", aluresultW, 32'd0);
    chk("rst_readdataW", readdataW, 32'd0);
    chk("rst_RdW", {27'd0, RdW}, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err_o}, 32'd0);
    idle_inputs();
    rst = 1'b0;
    tick();

    // ALU op
    regwriteM = 1; RdM = 5; aluresultM = 32'h1234;
    #1;
    chk("alu_stall", {31'd0, stall_o}, 32'd0);
    chk("alu_req", {31'd0, dmem_req_o}, 32'd0);
    tick();
    chk("alu_regwriteW", {31'd0, regwriteW}, 32'd1);
    chk("alu_RdW", {27'd0, RdW}, 32'd5);
    chk("alu_aluresultW", aluresultW, 32'h1234);
    chk("alu_stall_after", {31'd0, stall_o}, 32'd0);
    idle_inputs();

    // Store, grant after two cycles
    memwriteM = 1; aluresultM = 32'h100; Rd2M = 32'hDEADBEEF;
    #1;
    chk("st_req", {31'd0, dmem_req_o}, 32'd1);
    chk("st_we", {31'd0, dmem_we_o}, 32'd1);
    chk("st_addr", dmem_addr_o, 32'h100);
    chk("st_wdata", dmem_wdata_o, 32'hDEADBEEF);
    chk("st_stall_c0", {31'd0, stall_o}, 32'd1);
    tick();
    chk("st_stall_c1", {31'd0, stall_o}, 32'd1);
    chk("st_bubble_regwriteW", {31'd0, regwriteW}, 32'd0);
    tick();
    dmem_gnt_i = 1;
    #1;
    chk("st_stall_c2", {31'd0, stall_o}, 32'd0);
    tick();
    chk("st_done_regwriteW", {31'd0, regwriteW}, 32'd0);
    chk("st_done_aluresultW", aluresultW, 32'h100);
    chk("st_done_readdataW", readdataW, 32'd0);
    idle_inputs();

    // Load, grant at cycle 0, rvalid at cycle 3
    resultsrcM = 1; regwriteM = 1; RdM = 7; aluresultM = 32'h200; dmem_gnt_i = 1;
    #1;
    chk("ld_req_c0", {31'd0, dmem_req_o}, 32'd1);
    chk("ld_we_c0", {31'd0, dmem_we_o}, 32'd0);
    chk("ld_stall_c0", {31'd0, stall_o}, 32'd1);
    tick();
    dmem_gnt_i = 0;
    #1;
    chk("ld_req_c1", {31'd0, dmem_req_o}, 32'd0);
    chk("ld_stall_c1", {31'd0, stall_o}, 32'd1);
    chk("ld_bubble_regwriteW", {31'd0, regwriteW}, 32'd0);
    chk("ld_bubble_RdW", {27'd0, RdW}, 32'd0);
    tick();
    chk("ld_stall_c2", {31'd0, stall_o}, 32'd1);
    tick();
    dmem_rvalid_i = 1; dmem_rdata_i = 32'hCAFEF00D;
    #1;
    chk("ld_stall_c3", {31'd0, stall_o}, 32'd0);
    tick();
    chk("ld_readdataW", readdataW, 32'hCAFEF00D);
    chk("ld_RdW", {27'd0, RdW}, 32'd7);
    chk("ld_regwriteW", {31'd0, regwriteW}, 32'd1);
    chk("ld_resultsrcW", {31'd0, resultsrcW}, 32'd1);
    idle_inputs();

    // Back-to-back load then store, both single-cycle
    resultsrcM = 1; regwriteM = 1; RdM = 9; aluresultM = 32'h300;
    dmem_gnt_i = 1; dmem_rvalid_i = 1; dmem_rdata_i = 32'h11112222;
    #1;
    chk("b2b_ld_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("b2b_ld_readdataW", readdataW, 32'h11112222);
    chk("b2b_ld_RdW", {27'd0, RdW}, 32'd9);
    resultsrcM = 0; regwriteM = 0; RdM = 0; memwriteM = 1;
    aluresultM = 32'h304; Rd2M = 32'h5555; dmem_rvalid_i = 0; dmem_rdata_i = 32'hFFFF0000;
    #1;
    chk("b2b_st_stall", {31'd0, stall_o}, 32'd0);
    chk("b2b_st_we", {31'd0, dmem_we_o}, 32'd1);
    tick();
    chk("b2b_st_aluresultW", aluresultW, 32'h304);
    chk("b2b_st_regwriteW", {31'd0, regwriteW}, 32'd0);
    chk("b2b_st_readdataW_held", readdataW, 32'h11112222);
    idle_inputs();

    // rvalid with no access outstanding is ignored
    regwriteM = 1; RdM = 3; aluresultM = 32'h42;
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h00000BAD;
    tick();
    chk("idle_rvalid_readdataW", readdataW, 32'h11112222);
    chk("idle_RdW", {27'd0, RdW}, 32'd3);
    idle_inputs();

    // Reset while waiting in RESP; late rvalid must not be captured
    resultsrcM = 1; regwriteM = 1; RdM = 4; aluresultM = 32'h400; dmem_gnt_i = 1;
    tick();
    dmem_gnt_i = 0;
    #1;
    chk("rr_stall_resp", {31'd0, stall_o}, 32'd1);
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rr_stall", {31'd0, stall_o}, 32'd0);
    chk("rr_readdataW", readdataW, 32'd0);
    chk("rr_regwriteW", {31'd0, regwriteW}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h00000099;
    #1;
    chk("rr_late_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("rr_late_readdataW", readdataW, 32'd0);
    chk("rr_late_regwriteW", {31'd0, regwriteW}, 32'd0);
    idle_inputs();

`ifdef MEM_TIMEOUT_EN
    // Store never granted: three stalled cycles, abort on the fourth
    memwriteM = 1; aluresultM = 32'h500; Rd2M = 32'h1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("to_stall", {31'd0, stall_o}, 32'd1);
      tick();
      chk("to_no_err", {31'd0, mem_err_o}, 32'd0);
    end
    #1;
    chk("to_abort_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("to_err_pulse", {31'd0, mem_err_o}, 32'd1);
    chk("to_regwriteW", {31'd0, regwriteW}, 32'd0);
    chk("to_readdataW", readdataW, 32'd0);
    idle_inputs();
    tick();
    chk("to_err_clear", {31'd0, mem_err_o}, 32'd0);
    chk("to_idle_stall", {31'd0, stall_o}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
